// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver types and constants; PARITY state is used only with UART_RX_PARITY_EN
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} uart_rx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLKS_PER_BIT = 87;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO; a pop in the same cycle frees a full slot for the push
module uart_rx_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling UART receiver into a FIFO; define UART_RX_PARITY_EN for 8E1 framing
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  input  logic                          err_clr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  uart_rx_state_t state;
  logic [1:0] sync;
  logic s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic push, fe_set, full, empty, ov_set;
`ifdef UART_RX_PARITY_EN
  logic par_bad, pe_set;
`endif
  assign s = sync[1];
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], rx_i};
  end
  // push/fe_set are registered pulses, so FIFO and flags move one cycle after the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      push <= 1'b0;
      fe_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      pe_set <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      fe_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_set <= 1'b0;
`endif
      case (state)
        IDLE: if (ena && !s) begin
          state <= START;
          cnt <= CW'(CLKS_PER_BIT / 2 - 1);
        end
        START: if (cnt != '0) cnt <= cnt - CW'(1);
        else begin
          cnt <= CW'(CLKS_PER_BIT - 1);
          bit_idx <= '0;
          state <= s ? IDLE : DATA;
        end
        DATA: if (cnt != '0) cnt <= cnt - CW'(1);
        else begin
          cnt <= CW'(CLKS_PER_BIT - 1);
          shreg <= {s, shreg[UART_DATA_BITS-1:1]};
          bit_idx <= bit_idx + BW'(1);
`ifdef UART_RX_PARITY_EN
          if (bit_idx == BW'(UART_DATA_BITS - 1)) state <= PARITY;
`else
          if (bit_idx == BW'(UART_DATA_BITS - 1)) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt != '0) cnt <= cnt - CW'(1);
        else begin
          cnt <= CW'(CLKS_PER_BIT - 1);
          par_bad <= s != ^shreg;
          pe_set <= s != ^shreg;
          state <= STOP;
        end
`endif
        STOP: if (cnt != '0) cnt <= cnt - CW'(1);
        else begin
`ifdef UART_RX_PARITY_EN
          push <= s && !par_bad;
`else
          push <= s;
`endif
          fe_set <= !s;
          state <= s ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: if (s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign ov_set = push && full && !rx_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= fe_set || (frame_err && !err_clr);
      overrun <= ov_set || (overrun && !err_clr);
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else parity_err <= pe_set || (parity_err && !err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif
  assign rx_valid = !empty;
  uart_rx_fifo #(.W(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(shreg),
    .pop(rx_ready),
    .dout(rx_data),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed and random frames checked against a queue-based receive model
module tb_uart_rx_frontend;
  localparam int CPB = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 0, rst = 1, ena = 1, rx_i = 1, rx_ready = 0, err_clr = 0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, parity_err;
  logic [2:0] fifo_count;
  int n_checks = 0, n_fail = 0;
  logic [7:0] q[$];
  logic exp_fe = 0, exp_ov = 0, exp_pe = 0;

  uart_rx_frontend #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .rx_i(rx_i), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // drives one frame bit-period by bit-period, starting and ending on a falling clock edge
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop, par_ok ? ^d : ~^d, d, 1'b0};
`else
    bits = {1'b1, stop, d, 1'b0};
`endif
    for (int i = 0; i < NB; i++) begin
      rx_i = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic par_ok);
    if (!stop) exp_fe = 1;
    if (!par_ok) exp_pe = 1;
    if (stop && par_ok) begin
      if (q.size() < DEPTH) q.push_back(d);
      else exp_ov = 1;
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input logic par_ok);
    send_frame(d, stop, par_ok);
    model_frame(d, stop, par_ok);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, "_valid"}, 32'(rx_valid), 32'(q.size() != 0));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(exp_fe));
    chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ov));
    chk({tag, "_parity_err"}, 32'(parity_err), 32'(exp_pe));
  endtask

  task automatic drain(input string tag);
    rx_ready = 1;
    while (q.size() != 0) begin
      chk({tag, "_pop_valid"}, 32'(rx_valid), 1);
      chk({tag, "_pop_data"}, 32'(rx_data), 32'(q.pop_front()));
      @(negedge clk);
    end
    chk({tag, "_empty"}, 32'(rx_valid), 0);
    rx_ready = 0;
  endtask

  task automatic clear_flags();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    exp_fe = 0;
    exp_ov = 0;
    exp_pe = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset_data", 32'(rx_data), 0);
    rst = 0;
    repeat (4) @(negedge clk);

    // single byte with exact arrival cycle
    fork
      send_frame(8'hA5, 1, 1);
      begin
        repeat (NB * CPB - 1) @(negedge clk);
        chk("a5_valid_before", 32'(rx_valid), 0);
        @(negedge clk);
        chk("a5_valid_rise", 32'(rx_valid), 1);
        chk("a5_data", 32'(rx_data), 8'hA5);
      end
    join
    model_frame(8'hA5, 1, 1);
    repeat (3) @(negedge clk);
    check_state("a5");
    drain("a5");

    // back-to-back bytes, drained on consecutive cycles
    frame(8'h00, 1, 1);
    frame(8'hFF, 1, 1);
    frame(8'h3C, 1, 1);
    frame(8'h81, 1, 1);
    repeat (3) @(negedge clk);
    check_state("b2b");
    drain("b2b");

    // overrun: fifth byte dropped
    for (int i = 0; i < 5; i++) frame(8'($urandom), 1, 1);
    repeat (3) @(negedge clk);
    check_state("ovr");
    drain("ovr");
    clear_flags();
    check_state("ovr_clr");

    // false start
    rx_i = 0;
    repeat (2) @(negedge clk);
    rx_i = 1;
    repeat (40) @(negedge clk);
    check_state("false_start");

    // enable low ignores the line
    ena = 0;
    send_frame(8'h5A, 1, 1);
    repeat (4) @(negedge clk);
    ena = 1;
    check_state("ena_low");

    // framing error followed by a held break
    rx_i = 0;
    begin
      logic [7:0] b;
      b = 8'h55;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rx_i = b[i];
      end
`ifdef UART_RX_PARITY_EN
      repeat (CPB) @(negedge clk);
      rx_i = ^b;
`endif
      repeat (CPB) @(negedge clk);
      rx_i = 0;
      repeat (CPB + 40) @(negedge clk);
    end
    exp_fe = 1;
    check_state("break");
    rx_i = 1;
    repeat (60) @(negedge clk);
    check_state("break_release");

    // reset mid-frame with bytes queued and a sticky flag set
    frame(8'h12, 1, 1);
    frame(8'h34, 1, 1);
    repeat (2) @(negedge clk);
    check_state("pre_rst");
    rx_i = 0;
    repeat (30) @(negedge clk);
    rst = 1;
    rx_i = 1;
    @(negedge clk);
    rst = 0;
    q.delete();
    exp_fe = 0;
    exp_ov = 0;
    exp_pe = 0;
    check_state("mid_rst");
    repeat (CPB) @(negedge clk);
    frame(8'hC3, 1, 1);
    repeat (3) @(negedge clk);
    check_state("post_rst");
    drain("post_rst");

    // random batches, occasional bad stop bit and overrun
    for (int b = 0; b < 4; b++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) frame(8'($urandom), ($urandom_range(0, 7) != 0), 1);
      repeat (3) @(negedge clk);
      check_state("rand");
      drain("rand");
      clear_flags();
      check_state("rand_clr");
    end

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1, 0);
    repeat (3) @(negedge clk);
    check_state("parity_bad");
    clear_flags();
    frame(8'h07, 1, 1);
    repeat (3) @(negedge clk);
    check_state("parity_ok");
    drain("parity_ok");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
